// File: rtl/pvt_monitor_pkg.sv
`timescale 1ns/1ps
// pvt_monitor_pkg
// Shared definitions for the PVT ring-oscillator meter:
//   - meter_state_e      : measurement sequencer states
//   - stage_count()      : NAND2 stage count of ring k (2*(base + k*step) + 1)
//   - sim_half_period_ps(): half period given to the behavioural ring k
package pvt_monitor_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RUN     = 3'd2,
    SETTLE  = 3'd3,
    CAPTURE = 3'd4
  } meter_state_e;

  // Behavioural ring k runs with a period of 20 ns + k * 10 ns.
  localparam int SIM_HALF_BASE_PS = 32'sd10000;
  localparam int SIM_HALF_STEP_PS = 32'sd5000;

  function automatic int stage_count(input int k, input int base_depth, input int depth_step);
    return 32'sd2 * (base_depth + k * depth_step) + 32'sd1;
  endfunction

  function automatic int sim_half_period_ps(input int k);
    return SIM_HALF_BASE_PS + k * SIM_HALF_STEP_PS;
  endfunction

endpackage

// File: rtl/ring_osc_n.sv
`timescale 1ns/1ps
// ring_osc_n
// One free-running ring oscillator of 2*DEPTH+1 NAND2 stages. The first
// stage is gated by ena; with ena=0 the ring parks with osc_out=1.
// Ports:
//   ena     in  : enable (1 = oscillate)
//   osc_out out : ring output
// Synthesis builds the real NAND ring; simulation uses a timed model.
module ring_osc_n #(
  parameter int DEPTH          = 20,
  parameter int HALF_PERIOD_PS = 0
) (
  input  logic ena,
  output logic osc_out
);

`ifdef SYNTHESIS
  // The nets must survive optimisation or the ring collapses.
  (* keep = "true", dont_touch = "true" *) logic [2*DEPTH:0] stage_s;

  assign stage_s[0] = ~(ena & stage_s[2*DEPTH]);
  for (genvar i = 1; i <= 2*DEPTH; i++) begin : g_stage
    assign stage_s[i] = ~(stage_s[i-1] & stage_s[i-1]);
  end
  assign osc_out = stage_s[2*DEPTH];
`else
  // Without an explicit half period, assume roughly 250 ps per stage.
  localparam int HALF_PS = (HALF_PERIOD_PS > 0) ? HALF_PERIOD_PS : (2*DEPTH + 1) * 250;

  logic osc_r;

  // Behavioural ring: parked at 1 while disabled, toggles every half period while enabled.
  always begin
    if (ena !== 1'b1) begin
      osc_r = 1'b1;
      @(ena);
    end else begin
      #(HALF_PS * 1ps);
      if (ena === 1'b1) begin
        osc_r = ~osc_r;
      end else begin
        osc_r = 1'b1;
      end
    end
  end

  assign osc_out = osc_r;
`endif

endmodule

// File: rtl/pvt_ring_meter.sv
`timescale 1ns/1ps
// pvt_ring_meter
// Counts rising edges of one of NUM_CH ring oscillators during a gate of
// win_cycles clk cycles, then hands the result to the clk domain.
// Ports:
//   clk, rst          : system clock, async active-high reset
//   start             : one-cycle measurement request (ignored while busy)
//   ch_sel, win_cycles: channel and gate length, sampled at start
//   busy, done        : measurement in progress / one-cycle result strobe
//   count, overflow   : captured edge count and saturation flag
//   osc_mon           : raw output of the selected ring
module pvt_ring_meter
  import pvt_monitor_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int BASE_DEPTH = 20,
  parameter int DEPTH_STEP = 5,
  parameter int WIN_W      = 16,
  parameter int CNT_W      = 20,
  parameter int SETTLE_CYC = 4,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CH_W-1:0]  ch_sel,
  input  logic [WIN_W-1:0] win_cycles,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             osc_mon
);

  localparam logic [WIN_W-1:0] WIN_ZERO    = {WIN_W{1'b0}};
  localparam logic [WIN_W-1:0] WIN_ONE     = {{(WIN_W-1){1'b0}}, 1'b1};
  localparam logic [WIN_W-1:0] SETTLE_LOAD = WIN_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  meter_state_e     state_r, state_s;
  logic [WIN_W-1:0] timer_r, timer_s;
  logic [WIN_W-1:0] win_r;
  logic [CH_W-1:0]  ch_r;
  logic             gate_r, clr_r, busy_r, done_r, ovf_r;
  logic [CNT_W-1:0] count_r;
  logic             accept_s, ch_ok_s;

  logic [NUM_CH-1:0] osc_s, ring_ena_s;
  logic              cnt_clk_s, osc_rst_s;
  logic [1:0]        gate_sync_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              cnt_ovf_r;

  // busy_r also covers the done cycle, so a start coinciding with done is dropped.
  assign accept_s = (state_r == IDLE) && start && !busy_r;
  assign ch_ok_s  = (32'(ch_sel) < NUM_CH);

  // Next-state and timer logic of the measurement sequencer.
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = CLEAR;
        end else begin
          state_s = IDLE;
        end
      end
      CLEAR: begin
        timer_s = win_r;
        if (win_r == WIN_ZERO) begin
          state_s = CAPTURE;
        end else begin
          state_s = RUN;
        end
      end
      RUN: begin
        if (timer_r <= WIN_ONE) begin
          state_s = SETTLE;
          timer_s = SETTLE_LOAD;
        end else begin
          timer_s = timer_r - WIN_ONE;
        end
      end
      SETTLE: begin
        if (timer_r <= WIN_ONE) begin
          state_s = CAPTURE;
        end else begin
          timer_s = timer_r - WIN_ONE;
        end
      end
      CAPTURE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        timer_s = WIN_ZERO;
      end
    endcase
  end

  // clk-domain registers: state, latched request, gate/clear strobes, results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      timer_r <= WIN_ZERO;
      win_r   <= WIN_ZERO;
      ch_r    <= {CH_W{1'b0}};
      gate_r  <= 1'b0;
      clr_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      count_r <= CNT_ZERO;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      timer_r <= timer_s;
      // Only accepted in IDLE, where every ring is parked at 1.
      if (accept_s) begin
        ch_r  <= ch_ok_s ? ch_sel : {CH_W{1'b0}};
        win_r <= win_cycles;
      end
      gate_r <= (state_s == RUN);
      clr_r  <= (state_s == CLEAR);
      busy_r <= (state_s != IDLE) || (state_r == CAPTURE);
      done_r <= (state_r == CAPTURE);
      // Ring is stopped and settled here, so the counter is quiescent.
      if (state_r == CAPTURE) begin
        count_r <= cnt_r;
        ovf_r   <= cnt_ovf_r;
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ring
    assign ring_ena_s[k] = gate_r & (ch_r == CH_W'(k));
    ring_osc_n #(
      .DEPTH          ((stage_count(k, BASE_DEPTH, DEPTH_STEP) - 1) / 2),
      .HALF_PERIOD_PS (sim_half_period_ps(k))
    ) u_ring (
      .ena     (ring_ena_s[k]),
      .osc_out (osc_s[k])
    );
  end

  assign cnt_clk_s = osc_s[ch_r];
  assign osc_rst_s = rst | clr_r;

  // Gate synchroniser into the ring domain; falling-edge sampling loses only one rising edge at gate start.
  always_ff @(negedge cnt_clk_s or posedge osc_rst_s) begin
    if (osc_rst_s) begin
      gate_sync_r <= 2'b00;
    end else begin
      gate_sync_r <= {gate_sync_r[0], gate_r};
    end
  end

  // Saturating edge counter in the ring domain.
  always_ff @(posedge cnt_clk_s or posedge osc_rst_s) begin
    if (osc_rst_s) begin
      cnt_r     <= CNT_ZERO;
      cnt_ovf_r <= 1'b0;
    end else if (gate_sync_r[1]) begin
      if (cnt_r == CNT_MAX) begin
        cnt_ovf_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign count    = count_r;
  assign overflow = ovf_r;
  assign osc_mon  = cnt_clk_s;

endmodule

// File: tb/tb_pvt_ring_meter.sv
`timescale 1ns/1ps
// tb_pvt_ring_meter
// Directed measurements against a timeline model of the meter: every
// accepted start defines when busy, done and the ring enable must be high
// and which count window the result must fall into (edges = gate time /
// ring period, +/-1, saturated at 255 for an 8-bit counter).
module tb_pvt_ring_meter;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int SETTLE = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       ch_sel = 2'd0;
  logic [15:0]      win_cycles = 16'd0;
  logic             busy, done, overflow, osc_mon;
  logic [CNT_W-1:0] count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  pvt_ring_meter #(
    .NUM_CH     (NUM_CH),
    .BASE_DEPTH (20),
    .DEPTH_STEP (5),
    .WIN_W      (16),
    .CNT_W      (CNT_W),
    .SETTLE_CYC (SETTLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ch_sel     (ch_sel),
    .win_cycles (win_cycles),
    .busy       (busy),
    .done       (done),
    .count      (count),
    .overflow   (overflow),
    .osc_mon    (osc_mon)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  // Timeline model of the current measurement (cycle n = state after posedge n).
  int m_e0 = -1000;
  int m_w = 0;
  int m_ch = 0;
  int m_len = 0;
  int quiet_from = 0;
  int exp_lo = 0;
  int exp_hi = 0;
  int exp_ovf = 0;

  // Model update and per-cycle comparison, sampled on the falling clk edge.
  always @(negedge clk) begin
    int  n, nom, exp_ena;
    bit  m_busy, m_done, m_run, ring_live;
    n = cyc;
    if (rst) begin
      m_e0 = -1000; m_w = 0; m_len = 0;
      exp_lo = 0; exp_hi = 0; exp_ovf = 0;
      quiet_from = n + 3;
    end
    m_busy = (n >= m_e0) && (n < m_e0 + m_len);
    m_done = (n == m_e0 + m_len - 1);
    m_run  = (n >= m_e0 + 1) && (n <= m_e0 + m_w);
    if (m_done) begin
      if (m_w == 0) begin
        exp_lo = 0; exp_hi = 0; exp_ovf = 0;
      end else begin
        nom = (m_w * 20) / (20 + 10 * m_ch);
        if (nom - 1 > 255) begin
          exp_lo = 255; exp_hi = 255; exp_ovf = 1;
        end else begin
          exp_lo = nom - 1; exp_hi = nom + 1; exp_ovf = 0;
        end
      end
    end
    exp_ena = m_run ? (1 << m_ch) : 0;
    check_eq("busy", busy, m_busy);
    check_eq("done", done, m_done);
    check_eq("ring_ena", int'(dut.ring_ena_s), exp_ena);
    check_rng("count_hold", count, exp_lo, exp_hi);
    check_eq("overflow_hold", overflow, exp_ovf);
    // A stopped ring may need up to one half period to park at 1.
    ring_live = (n >= m_e0 + 1) && (n <= m_e0 + m_w + 2);
    if (!ring_live && n >= quiet_from) begin
      check_eq("osc_mon_idle", osc_mon, 1);
    end
    if (!rst && start && !m_busy) begin
      m_e0  = n + 1;
      m_w   = int'(win_cycles);
      m_ch  = (int'(ch_sel) < NUM_CH) ? int'(ch_sel) : 0;
      m_len = (m_w == 0) ? 3 : m_w + SETTLE + 3;
    end
  end

  // Call right after a rising edge; drives one start and waits for done.
  task automatic run_meas(input int ch, input int w, input int exp_lat,
                          input int lo, input int hi, input int ovf, input bit spam);
    int t0, t_done, busy_cycles;
    bit seen;
    start = 1'b1; ch_sel = 2'(ch); win_cycles = 16'(w);
    t0 = cyc; t_done = 0; busy_cycles = 0; seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk); #1;
      start = spam && (i % 3 == 1);
      if (spam) ch_sel = 2'd3;
      if (busy) busy_cycles++;
      if (done) begin
        seen = 1'b1;
        t_done = cyc;
        start = spam;
      end
    end
    check_eq("done_seen", seen, 1);
    check_eq("latency", t_done - t0, exp_lat);
    check_eq("busy_cycles", busy_cycles, exp_lat);
    check_rng("count", count, lo, hi);
    check_eq("overflow", overflow, ovf);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int dones;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_count", count, 0);
    rst = 1'b0;
    #1;
    check_eq("idle_done", done, 0);
    check_eq("idle_overflow", overflow, 0);
    check_eq("idle_osc_mon", osc_mon, 1);

    @(posedge clk); #1; run_meas(0, 100, 107, 99, 101, 0, 1'b0);
    @(posedge clk); #1; run_meas(2, 200, 207, 99, 101, 0, 1'b0);
    @(posedge clk); #1; run_meas(0, 1000, 1007, 255, 255, 1, 1'b0);
    @(posedge clk); #1; run_meas(0, 10, 17, 9, 11, 0, 1'b0);
    @(posedge clk); #1; run_meas(1, 0, 3, 0, 0, 0, 1'b0);
    @(posedge clk); #1; run_meas(1, 30, 37, 19, 21, 0, 1'b0);
    // ch_sel beyond NUM_CH-1 falls back to ring 0
    @(posedge clk); #1; run_meas(3, 20, 27, 19, 21, 0, 1'b0);
    // extra starts while busy and in the done cycle
    @(posedge clk); #1; run_meas(2, 8, 15, 3, 5, 0, 1'b1);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check_eq("extra_done", dones, 0);
    check_eq("extra_busy", busy, 0);

    // reset in the middle of RUN
    @(posedge clk); #1;
    start = 1'b1; ch_sel = 2'd0; win_cycles = 16'd100;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #6;
    rst = 1'b1;
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_count", count, 0);
    check_eq("midrst_overflow", overflow, 0);
    check_eq("midrst_ena", int'(dut.ring_ena_s), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    run_meas(1, 30, 37, 19, 21, 0, 1'b0);
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pvt_ring_meter.md
PVT_RING_METER -- requirements
Module: pvt_ring_meter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of ring-oscillator channels.
REQ-002 SHALL have parameter BASE_DEPTH, default 20: channel 0 has 2*BASE_DEPTH+1 NAND2 stages.
REQ-003 SHALL have parameter DEPTH_STEP, default 5: channel k has 2*(BASE_DEPTH+k*DEPTH_STEP)+1 stages.
REQ-004 SHALL have parameter WIN_W, default 16: width of the measurement-window length.
REQ-005 SHALL have parameter CNT_W, default 20: width of the edge counter and result.
REQ-006 SHALL have parameter SETTLE_CYC, default 4: clk cycles waited after the gate falls before capture.
REQ-007 clk  input  1  single system clock; all control logic is on its rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 start  input  1  one-cycle request to begin a measurement.
REQ-010 ch_sel  input  $clog2(NUM_CH)  channel to measure; sampled at start.
REQ-011 win_cycles  input  WIN_W  gate length in clk cycles; sampled at start.
REQ-012 busy  output  1  high from the cycle after start is accepted until done.
REQ-013 done  output  1  one-cycle pulse when count and overflow are valid.
REQ-014 count  output  CNT_W  rising edges of the selected oscillator counted during the gate.
REQ-015 overflow  output  1  counter saturated during the last measurement.
REQ-016 osc_mon  output  1  raw output of the selected ring, for pad debug.

Function
REQ-017 SHALL be an FSM with states IDLE, CLEAR, RUN, SETTLE, CAPTURE.
- IDLE: start=1 -> CLEAR; latch ch_sel and win_cycles.
- Out-of-range ch_sel is latched as 0.
- CLEAR lasts 1 cycle, then RUN; if latched win_cycles==0, go directly to CAPTURE.
- RUN lasts exactly win_cycles cycles, then SETTLE.
- SETTLE lasts exactly SETTLE_CYC cycles, then CAPTURE.
- CAPTURE lasts 1 cycle, then IDLE.
REQ-018 start SHALL be ignored while busy=1; a start arriving in the same cycle as done SHALL be ignored.
REQ-019 In CLEAR, a registered, glitch-free clear pulse SHALL asynchronously clear the osc-domain counter and overflow flag.
REQ-020 A registered gate SHALL be high only in RUN and SHALL drive the ena input of the selected ring only; all other rings have ena=0.
REQ-021 Ring select, counter clock mux and latched channel SHALL change only while every ring ena is 0, so that the muxed clock stays at constant 1.
REQ-022 The osc-domain counter SHALL increment on each rising edge of the selected ring while a 2-flop osc-domain synchroniser of the gate is high.
REQ-023 The counter SHALL saturate at 2^CNT_W-1 and then set overflow; it SHALL never wrap.
REQ-024 In CAPTURE, count and overflow SHALL be registered into the clk domain from the quiescent counter.
- This transfer needs no synchroniser because the ring is stopped.
REQ-025 done SHALL pulse in the cycle after CAPTURE; count and overflow SHALL hold until the next CAPTURE.
REQ-026 Latency from the start edge to done SHALL be win_cycles+SETTLE_CYC+3 clk cycles.
- For win_cycles==0 the latency is 3 cycles, with count=0 and overflow=0.
REQ-027 osc_mon SHALL be the selected ring output; it is 1 whenever that ring is disabled.

Reset
REQ-028 rst SHALL asynchronously force the following, regardless of state (mid-measurement included):
- FSM to IDLE; gate=0, so all rings stop.
- busy=0, done=0, count=0, overflow=0.
- Latched ch_sel=0, latched win_cycles=0.
- Osc-domain counter and its synchroniser to 0.
REQ-029 After rst falls, the block SHALL accept start on the first clk edge.

Structure
REQ-030 Package pvt_monitor_pkg SHALL hold:
- the FSM state enum;
- a function returning the stage count of channel k from BASE_DEPTH and DEPTH_STEP.
REQ-031 Sub-module ring_osc_n SHALL implement one ring:
- parameter DEPTH (2*DEPTH+1 NAND2 stages); ports ena, osc_out;
- keep/dont_touch attributes on the ring nets;
- under a simulation define, a behavioural model with parameter HALF_PERIOD_PS.
REQ-032 pvt_ring_meter SHALL instantiate NUM_CH ring_osc_n through a generate loop.

Verification (behavioural rings; clk period 20 ns; channel k period 20+10k ns; SETTLE_CYC=4)
REQ-033 start, ch_sel=0, win_cycles=100 -> busy high for 107 cycles; done 107 cycles after start; count in 99..101; overflow=0.
REQ-034 ch_sel=2 (40 ns), win_cycles=200 -> count in 99..101; only ring 2 ena toggles; osc_mon=1 outside RUN.
REQ-035 CNT_W=8, ch_sel=0, win_cycles=1000 -> count=255, overflow=1; the next measurement with win_cycles=10 gives count 9..11, overflow=0.
REQ-036 win_cycles=0 -> done 3 cycles after start; count=0; no ring ena pulse.
REQ-037 rst asserted mid-RUN -> all outputs 0 and all ena 0 immediately, asynchronously; a new start after release completes normally.
REQ-038 start repeated while busy, and start coinciding with done -> ignored; exactly one done per accepted start.
